mux_word_pipe: RTL and testbench
================================

// Module: mux_word_pipe
// PURPOSE
//  Parametrised NUM_IN-to-1 word selector built as a binary 2:1 mux tree.
//  A pipeline register sits after every REG_EVERY tree levels.
//  Each stage has a valid/ready handshake with stall and bubble collapse, plus a tag side-band.
//  Serves register-file read ports and forwarding selection in the pipelined CPU datapath,
//  where a single-cycle 32:1 tree would break timing.
// PARAMETERS
//  WIDTH      64                            bits per input word
//  NUM_IN     32                            number of inputs, >=2; need not be a power of 2
//  REG_EVERY  2                             tree levels between pipeline registers, >=1
//  TAG_W      5                             side-band tag width, carried unmodified
//  SEL_W      $clog2(NUM_IN)                select width (derived, do not override)
//  LAT        ceil(SEL_W/REG_EVERY)         pipeline depth (derived); default = 3
// PORTS
//  clk        in   1             clock, rising edge
//  reset      in   1             synchronous, active-high
//  in_valid   in   1             request present
//  in_ready   out  1             request accepted this cycle when in_valid && in_ready
//  in_data    in   NUM_IN*WIDTH  word i at [i*WIDTH +: WIDTH]
//  in_sel     in   SEL_W         binary index of selected word
//  in_tag     in   TAG_W         request tag
//  out_valid  out  1             result present
//  out_ready  in   1             consumer takes result when out_valid && out_ready
//  out_data   out  WIDTH         selected word
//  out_tag    out  TAG_W         tag of this result
//  out_err    out  1             in_sel was >= NUM_IN; out_data is 0
// BEHAVIOUR
//  Tree structure
//  - Level j (j=0 is the input side) uses sel bit j.
//  - Stage k holds levels k*REG_EVERY .. min((k+1)*REG_EVERY, SEL_W)-1, then a register.
//    The last stage register drives the out_* ports.
//  - Each stage register holds: valid, the partial words for that level, the unused
//    upper sel bits, the tag, and the err bit.
//  Operands
//  - in_data, in_sel and in_tag are sampled only on the accept cycle.
//  - They may change freely on any other cycle.
//  - Tree slots at index >= NUM_IN are tied to 0.
//  - err = (in_sel >= NUM_IN) is computed at accept and travels with the item.
//  - When err=1, out_data is forced to 0.
//  Handshake, per stage k
//  - adv_k = !valid_k || ready_(k+1). ready_LAT = out_ready. in_ready = adv_0.
//  - When adv_k: valid_k <= valid_(k-1), where valid_(-1) = in_valid; the stage payload loads.
//  - When !adv_k: the stage holds its contents; data is never dropped or duplicated.
//  - Ready chain is combinational from out_ready to in_ready.
//  Timing
//  - Latency: an item accepted in cycle t appears on out_* in cycle t+LAT if no stall.
//  - Throughput: 1 item/cycle while out_ready=1.
//  - Output stays stable (data, tag, err) while out_valid && !out_ready.
//  Full pipeline
//  - All LAT stages valid with out_ready=0: in_ready=0.
//  - Same case with out_ready=1: accept and retire happen in the same cycle.
//  - Items retire in strict acceptance order.
//  Bubble collapse
//  - An empty stage accepts from upstream even while downstream is stalled.
//  - Up to LAT items buffer under a stall.
//  Reset
//  - All valid bits 0; out_valid=0, out_data=0, out_tag=0, out_err=0.
//  - in_ready=1 in the first cycle after reset.
//  - Reset mid-operation discards all in-flight items; no partial result is emitted.
//  - Accept attempts during the reset cycle are ignored.
//  Degenerate case
//  - REG_EVERY >= SEL_W gives a single stage: LAT=1, still registered output.
// TESTING
//  1. Reset; in[i]=32'hA5A5_0000+i; sel=7, tag=3, one-cycle pulse, out_ready=1
//     -> out_valid exactly 3 cycles later; out_data=..A5A5_0007, tag=3, err=0.
//  2. Stream sel=0..31 back to back with out_ready=1
//     -> after 3 cycles, one result per cycle; words 0..31 in order; in_ready stays 1.
//  3. Stream with out_ready=0 for 6 cycles
//     -> exactly 3 items buffered, in_ready=0 from the 4th cycle, out_* stable;
//     on release, all items arrive in order with none lost or duplicated.
//  4. NUM_IN=20: sel=25 -> out_err=1, out_data=0.
//     sel=19 -> in[19], out_err=0.
//  5. reset held 1 cycle with 2 items in flight
//     -> next cycle out_valid=0, in_ready=1; neither item is ever emitted.
//  6. REG_EVERY=8, NUM_IN=2, sel=1 -> LAT=1, result in the next cycle.
//     Simultaneous accept and retire under out_ready=1 sustains 1 item/cycle.

Source files
------------

// File: rtl/mux_word_pipe.sv
// mux_word_pipe
//   NUM_IN-to-1 word selector built as a binary 2:1 mux tree. There is a
//   register stage after every REG_EVERY tree levels. Each stage uses a
//   valid/ready handshake with bubble collapse, and a tag and an error bit
//   travel with each item. A select value >= NUM_IN addresses one of the
//   zero-tied padding slots, so for such an item out_data comes out as 0
//   and out_err is set.
module mux_word_pipe #(
    parameter int WIDTH       = 64,
    parameter int NUM_IN      = 32,
    parameter int REG_EVERY   = 2,
    parameter int TAG_W       = 5,
    localparam int SEL_W      = $clog2(NUM_IN),
    localparam int LAT        = (SEL_W + REG_EVERY - 1) / REG_EVERY
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    out_err
);

    localparam logic [SEL_W:0] NUM_IN_V = (SEL_W + 1)'(NUM_IN);

    logic [LAT-1:0] w_stage_vld;
    logic [LAT:0]   w_rdy;

    // Ready ripples back from the consumer: a stage loads when it is empty or when its successor loads.
    always_comb begin
        w_rdy      = {(LAT + 1){1'b0}};
        w_rdy[LAT] = out_ready;
        for (int k = LAT - 1; k >= 0; k--) begin
            w_rdy[k] = !w_stage_vld[k] || w_rdy[k + 1];
        end
    end

    assign in_ready = w_rdy[0];

    for (genvar k = 0; k < LAT; k++) begin : g_stg
        localparam int LO     = k * REG_EVERY;
        localparam int HI     = ((k + 1) * REG_EVERY < SEL_W) ? (k + 1) * REG_EVERY : SEL_W;
        localparam int NL     = HI - LO;
        localparam int SW_IN  = SEL_W - LO;
        localparam int SW_OUT = (SEL_W - HI > 0) ? (SEL_W - HI) : 1;
        localparam int NW_IN  = 1 << SW_IN;
        localparam int NW_OUT = 1 << (SEL_W - HI);

        logic             w_up_vld;
        logic [WIDTH-1:0] w_words_in  [NW_IN];
        logic [SW_IN-1:0] w_sel_in;
        logic [TAG_W-1:0] w_tag_in;
        logic             w_err_in;
        logic [WIDTH-1:0] w_tree      [NW_IN];
        logic [WIDTH-1:0] w_words_out [NW_OUT];

        logic             r_valid;
        logic [WIDTH-1:0] r_words [NW_OUT];
        logic [TAG_W-1:0] r_tag;
        logic             r_err;

        if (k == 0) begin : g_src
            for (genvar i = 0; i < NW_IN; i++) begin : g_slot
                if (i < NUM_IN) begin : g_live
                    assign w_words_in[i] = in_data[i*WIDTH +: WIDTH];
                end else begin : g_pad
                    assign w_words_in[i] = {WIDTH{1'b0}};
                end
            end
            assign w_up_vld = in_valid;
            assign w_sel_in = in_sel;
            assign w_tag_in = in_tag;
            assign w_err_in = ({1'b0, in_sel} >= NUM_IN_V);
        end else begin : g_link
            for (genvar i = 0; i < NW_IN; i++) begin : g_slot
                assign w_words_in[i] = g_stg[k-1].r_words[i];
            end
            assign w_up_vld = w_stage_vld[k-1];
            assign w_sel_in = g_stg[k-1].g_sel.r_sel;
            assign w_tag_in = g_stg[k-1].r_tag;
            assign w_err_in = g_stg[k-1].r_err;
        end

        // Reduces the words through this stage's tree levels, in place; bit l of the local select drives level l.
        always_comb begin
            for (int i = 0; i < NW_IN; i++) begin
                w_tree[i] = w_words_in[i];
            end
            for (int l = 0; l < NL; l++) begin
                for (int i = 0; i < (NW_IN >> (l + 1)); i++) begin
                    w_tree[i] = w_sel_in[l] ? w_tree[2*i + 1] : w_tree[2*i];
                end
            end
            for (int i = 0; i < NW_OUT; i++) begin
                w_words_out[i] = w_tree[i];
            end
        end

        // Stage register: loads a new item when the stage advances and holds it under back-pressure.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_tag   <= {TAG_W{1'b0}};
                r_err   <= 1'b0;
                for (int i = 0; i < NW_OUT; i++) begin
                    r_words[i] <= {WIDTH{1'b0}};
                end
            end else if (w_rdy[k]) begin
                r_valid <= w_up_vld;
                if (w_up_vld) begin
                    r_tag <= w_tag_in;
                    r_err <= w_err_in;
                    for (int i = 0; i < NW_OUT; i++) begin
                        r_words[i] <= w_words_out[i];
                    end
                end
            end
        end

        if (k < LAT - 1) begin : g_sel
            logic [SW_OUT-1:0] r_sel;

            // Carries the select bits that later stages still need to consume.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sel <= {SW_OUT{1'b0}};
                end else if (w_rdy[k] && w_up_vld) begin
                    r_sel <= w_sel_in[SW_IN-1:NL];
                end
            end
        end

        assign w_stage_vld[k] = r_valid;
    end

    assign out_valid = w_stage_vld[LAT-1];
    assign out_data  = g_stg[LAT-1].r_words[0];
    assign out_tag   = g_stg[LAT-1].r_tag;
    assign out_err   = g_stg[LAT-1].r_err;

endmodule

// File: tb/tb_mux_word_pipe.sv
// Bench for mux_word_pipe: three instances share the stimulus.
//   a: 32 inputs, 3 stages
//   b: 20 inputs, exercises out-of-range selects
//   c: 2 inputs with REG_EVERY=8, giving a single stage
// Each instance has its own scoreboard queue. An entry is pushed when that
// instance accepts an item and popped when it retires one.
module tb_mux_word_pipe;
    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            in_valid;
    logic            out_ready;
    logic [4:0]      in_sel;
    logic [4:0]      in_tag;
    logic [32*W-1:0] in_data;

    logic a_in_ready, a_out_valid, a_out_err;
    logic b_in_ready, b_out_valid, b_out_err;
    logic c_in_ready, c_out_valid, c_out_err;
    logic [W-1:0] a_out_data, b_out_data, c_out_data;
    logic [4:0]   a_out_tag, b_out_tag, c_out_tag;

    mux_word_pipe #(.WIDTH(W), .NUM_IN(32), .REG_EVERY(2), .TAG_W(5)) u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_tag(a_out_tag), .out_err(a_out_err));

    mux_word_pipe #(.WIDTH(W), .NUM_IN(20), .REG_EVERY(2), .TAG_W(5)) u_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data[20*W-1:0]), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_tag(b_out_tag), .out_err(b_out_err));

    mux_word_pipe #(.WIDTH(W), .NUM_IN(2), .REG_EVERY(8), .TAG_W(5)) u_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data[2*W-1:0]), .in_sel(in_sel[0:0]), .in_tag(in_tag),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
        .out_tag(c_out_tag), .out_err(c_out_err));

    typedef struct {
        logic [4:0]  sel;
        logic [4:0]  tag;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
        logic        exp_err_b;
        logic [63:0] exp_c;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        logic        err;
    } item_t;

    item_t qa[$];
    item_t qb[$];
    item_t qc[$];
    vec_t  vt[$];
    vec_t  cur;
    int    n_checks = 0;
    int    n_pass   = 0;

    function automatic logic [63:0] word_of(int n_in, int s);
        if (s < n_in) return 64'hA5A5_0000 + 64'(s);
        else          return 64'h0;
    endfunction

    function automatic vec_t mk(int s, int t);
        vec_t v;
        v.sel       = 5'(s);
        v.tag       = 5'(t);
        v.exp_a     = word_of(32, s);
        v.exp_b     = word_of(20, s);
        v.exp_err_b = (s >= 20);
        v.exp_c     = word_of(2, s % 2);
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic check_item(string name, logic [63:0] d, logic [4:0] t, logic er, item_t e);
        n_checks++;
        if (d === e.data && t === e.tag && er === e.err) n_pass++;
        else $display("FAIL %s: got data %h tag %0d err %b, required data %h tag %0d err %b",
                      name, d, t, er, e.data, e.tag, e.err);
    endtask

    task automatic no_item(string name, logic [4:0] t, logic [63:0] d);
        n_checks++;
        $display("FAIL %s: got output tag %0d data %h, required no output", name, t, d);
    endtask

    task automatic apply(logic v, vec_t x);
        cur      = x;
        in_valid = v;
        in_sel   = x.sel;
        in_tag   = x.tag;
        #1;
    endtask

    // One clock cycle: record accepts, score retires, then advance past the edge.
    task automatic step();
        item_t e;
        #1;
        if (!reset) begin
            if (in_valid && a_in_ready) begin
                e.data = cur.exp_a; e.tag = cur.tag; e.err = 1'b0; qa.push_back(e);
            end
            if (in_valid && b_in_ready) begin
                e.data = cur.exp_b; e.tag = cur.tag; e.err = cur.exp_err_b; qb.push_back(e);
            end
            if (in_valid && c_in_ready) begin
                e.data = cur.exp_c; e.tag = cur.tag; e.err = 1'b0; qc.push_back(e);
            end
            if (a_out_valid && out_ready) begin
                if (qa.size() == 0) no_item("a_unexpected", a_out_tag, a_out_data);
                else begin e = qa.pop_front(); check_item("a_out", a_out_data, a_out_tag, a_out_err, e); end
            end
            if (b_out_valid && out_ready) begin
                if (qb.size() == 0) no_item("b_unexpected", b_out_tag, b_out_data);
                else begin e = qb.pop_front(); check_item("b_out", b_out_data, b_out_tag, b_out_err, e); end
            end
            if (c_out_valid && out_ready) begin
                if (qc.size() == 0) no_item("c_unexpected", c_out_tag, c_out_data);
                else begin e = qc.pop_front(); check_item("c_out", c_out_data, c_out_tag, c_out_err, e); end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string name);
        out_ready = 1'b1;
        for (int n = 0; n < 20 && (qa.size() + qb.size() + qc.size()) != 0; n++) step();
        check(name, 64'(qa.size() + qb.size() + qc.size()), 64'd0);
    endtask

    initial begin
        int idx;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_sel    = 5'd0;
        in_tag    = 5'd0;
        in_data   = '0;
        for (int i = 0; i < 32; i++) in_data[i*W +: W] = 64'hA5A5_0000 + 64'(i);
        for (int s = 0; s < 32; s++) vt.push_back(mk(s, (s * 7 + 3) % 32));
        vt.push_back(mk(19, 1));
        vt.push_back(mk(20, 2));
        vt.push_back(mk(25, 4));
        vt.push_back(mk(31, 6));
        cur = vt[0];

        // Reset state
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_out_valid", a_out_valid, 64'd0);
        check("rst_out_data",  a_out_data,  64'd0);
        check("rst_out_tag",   a_out_tag,   64'd0);
        check("rst_out_err",   a_out_err,   64'd0);
        check("rst_in_ready",  a_in_ready,  64'd1);
        check("rst_c_in_ready", c_in_ready, 64'd1);

        // Single pulse: a/b take 3 cycles, c takes 1 cycle
        apply(1'b1, mk(7, 3));
        step();
        apply(1'b0, mk(12, 9));
        check("t1_c_valid", c_out_valid, 64'd1);
        check("t1_c_data",  c_out_data,  64'hA5A5_0001);
        check("t1_a_valid_1", a_out_valid, 64'd0);
        step();
        check("t1_a_valid_2", a_out_valid, 64'd0);
        step();
        check("t1_a_valid_3", a_out_valid, 64'd1);
        check("t1_a_data",    a_out_data,  64'hA5A5_0007);
        check("t1_a_tag",     a_out_tag,   64'd3);
        check("t1_a_err",     a_out_err,   64'd0);
        step();
        drain("t1_drain");

        // Back-to-back stream of sel 0..31
        for (int i = 0; i < 32; i++) begin
            apply(1'b1, vt[i]);
            check("t2_in_ready", a_in_ready, 64'd1);
            check("t2_c_in_ready", c_in_ready, 64'd1);
            if (i >= 3) check("t2_out_valid", a_out_valid, 64'd1);
            if (i >= 1) check("t2_c_out_valid", c_out_valid, 64'd1);
            step();
        end
        apply(1'b0, vt[0]);
        drain("t2_drain");

        // Stall for 6 cycles: three items buffered, then release
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            apply(1'b1, vt[idx]);
            check("t3_in_ready", a_in_ready, (c < 3) ? 64'd1 : 64'd0);
            if (c >= 3) begin
                check("t3_out_valid", a_out_valid, 64'd1);
                check("t3_hold_data", a_out_data, vt[0].exp_a);
                check("t3_hold_tag",  a_out_tag,  64'(vt[0].tag));
            end
            if (a_in_ready) idx++;
            step();
        end
        check("t3_buffered", 64'(idx), 64'd3);
        out_ready = 1'b1;
        for (int n = 0; n < 40 && idx < 10; n++) begin
            apply(1'b1, vt[idx]);
            if (a_in_ready) idx++;
            step();
        end
        apply(1'b0, vt[0]);
        drain("t3_drain");

        // Out-of-range selects on b, then everything under random back-pressure
        for (int i = 32; i < 36; i++) begin
            apply(1'b1, vt[i]);
            step();
        end
        apply(1'b0, vt[0]);
        drain("t4_drain");
        idx = 0;
        for (int n = 0; n < 400 && idx < 36; n++) begin
            out_ready = 1'($urandom_range(0, 1));
            apply(1'b1, vt[idx]);
            if (a_in_ready) idx++;
            step();
        end
        check("t4_all_sent", 64'(idx), 64'd36);
        apply(1'b0, vt[0]);
        drain("t4r_drain");

        // Reset with two items in flight: neither item is ever emitted
        out_ready = 1'b1;
        apply(1'b1, vt[3]);
        step();
        apply(1'b1, vt[4]);
        step();
        apply(1'b1, vt[5]);
        reset = 1'b1;
        step();
        reset = 1'b0;
        apply(1'b0, vt[0]);
        qa.delete();
        qb.delete();
        qc.delete();
        check("t5_in_ready",  a_in_ready,  64'd1);
        check("t5_c_valid",   c_out_valid, 64'd0);
        check("t5_b_valid",   b_out_valid, 64'd0);
        for (int n = 0; n < 6; n++) begin
            check("t5_no_out", a_out_valid, 64'd0);
            step();
        end

        drain("final_empty");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
